// File: rtl/layer_sched.sv
// layer_sched
//   Sequences the conv/pool engine through one full layer. Each channel group
//   is run by holding engine_valid until the engine pulses group_done; the
//   scheduler then advances its input-channel / output-row / output-channel
//   counters (mirroring the engine's own) and pulses done after the last group.
//   A watchdog flags a stalled engine, and abort cancels the layer from any
//   active state.
//
// Parameters
//   BURST_LEN : channels per group (cur_ic step; cur_oc step for pooling ops)
//   TIMEOUT   : RUN cycles allowed without group_done before a timeout error
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle layer start request (accepted only in IDLE)
//   abort         : cancel current layer, return to IDLE
//   op_type       : 1 CONV, 2 MPOOL, 3 APOOL (latched on accepted start)
//   i_channel     : input channel count  (latched on accepted start)
//   o_channel     : output channel count (latched on accepted start)
//   o_side        : output rows per channel (latched on accepted start)
//   group_done    : engine pulse, current channel group finished
//   engine_valid  : run command to the engine, high throughout RUN
//   busy          : high in any state other than IDLE
//   done          : one-cycle pulse at layer completion
//   err, err_code : sticky error flag and code (1 bad config, 2 timeout)
//   cur_ic, cur_row, cur_oc : current group position
module layer_sched #(
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  op_type,
  input  logic [15:0] i_channel,
  input  logic [15:0] o_channel,
  input  logic [7:0]  o_side,
  input  logic        group_done,
  output logic        engine_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] cur_ic,
  output logic [7:0]  cur_row,
  output logic [15:0] cur_oc
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    NEXT,
    GAP,
    DONE,
    ERR
  } state_t;

  state_t      state;
  logic [2:0]  cfg_op;
  logic [15:0] cfg_ic;
  logic [15:0] cfg_oc;
  logic [7:0]  cfg_side;
  logic [31:0] wdog;

  logic        bad_cfg;
  logic [16:0] ic_sum;
  logic [16:0] oc_sum;
  logic [8:0]  row_sum;
  logic        ic_more;
  logic        row_more;
  logic        oc_end;

  // 17-bit sums keep the channel comparisons free of wrap-around.
  always_comb begin
    bad_cfg  = (op_type == 3'd0) || (op_type > 3'd3) ||
               (i_channel == '0) || (o_side == '0) || (o_channel == '0);
    ic_sum   = {1'b0, cur_ic} + 17'(BURST_LEN);
    oc_sum   = {1'b0, cur_oc} + ((cfg_op == 3'd1) ? 17'd1 : 17'(BURST_LEN));
    row_sum  = {1'b0, cur_row} + 9'd1;
    ic_more  = ic_sum < {1'b0, cfg_ic};
    row_more = row_sum < {1'b0, cfg_side};
    oc_end   = oc_sum >= {1'b0, cfg_oc};
  end

  // Outputs are registered: each transition sets the output values that
  // belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cfg_op       <= '0;
      cfg_ic       <= '0;
      cfg_oc       <= '0;
      cfg_side     <= '0;
      wdog         <= '0;
      engine_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= '0;
      cur_ic       <= '0;
      cur_row      <= '0;
      cur_oc       <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Abort outranks group_done and the watchdog; counters hold.
        state        <= IDLE;
        engine_valid <= 1'b0;
        busy         <= 1'b0;
        err          <= 1'b0;
        err_code     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              cfg_op   <= op_type;
              cfg_ic   <= i_channel;
              cfg_oc   <= o_channel;
              cfg_side <= o_side;
              cur_ic   <= '0;
              cur_row  <= '0;
              cur_oc   <= '0;
              wdog     <= '0;
              busy     <= 1'b1;
              if (bad_cfg) begin
                state    <= ERR;
                err      <= 1'b1;
                err_code <= 2'd1;
              end else begin
                state        <= RUN;
                engine_valid <= 1'b1;
              end
            end
          end
          RUN: begin
            // group_done on the expiry cycle still counts as success.
            if (group_done) begin
              state        <= NEXT;
              engine_valid <= 1'b0;
            end else if (wdog == 32'(TIMEOUT - 1)) begin
              state        <= ERR;
              engine_valid <= 1'b0;
              err          <= 1'b1;
              err_code     <= 2'd2;
            end else begin
              wdog <= wdog + 32'd1;
            end
          end
          NEXT: begin
            if (ic_more) begin
              cur_ic <= ic_sum[15:0];
              state  <= GAP;
            end else begin
              cur_ic <= '0;
              if (row_more) begin
                cur_row <= row_sum[7:0];
                state   <= GAP;
              end else begin
                cur_row <= '0;
                cur_oc  <= oc_sum[15:0];
                if (oc_end) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= GAP;
                end
              end
            end
          end
          GAP: begin
            state        <= RUN;
            engine_valid <= 1'b1;
            wdog         <= '0;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          ERR: begin
            // Holds until abort or rst.
            state <= ERR;
          end
          default: begin
            state        <= IDLE;
            engine_valid <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
module tb_layer_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [2:0]  op_type;
  logic [15:0] i_channel;
  logic [15:0] o_channel;
  logic [7:0]  o_side;
  logic        group_done;
  logic        engine_valid;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] cur_ic;
  logic [7:0]  cur_row;
  logic [15:0] cur_oc;

  int n_cmp = 0;
  int n_err = 0;

  layer_sched #(.BURST_LEN(8), .TIMEOUT(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .op_type      (op_type),
    .i_channel    (i_channel),
    .o_channel    (o_channel),
    .o_side       (o_side),
    .group_done   (group_done),
    .engine_valid (engine_valid),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .cur_ic       (cur_ic),
    .cur_row      (cur_row),
    .cur_oc       (cur_oc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".engine_valid"}, 32'(engine_valid), 32'd0);
    chk({tag, ".busy"},         32'(busy),         32'd0);
    chk({tag, ".done"},         32'(done),         32'd0);
    chk({tag, ".err"},          32'(err),          32'd0);
    chk({tag, ".err_code"},     32'(err_code),     32'd0);
    chk({tag, ".cur_ic"},       32'(cur_ic),       32'd0);
    chk({tag, ".cur_row"},      32'(cur_row),      32'd0);
    chk({tag, ".cur_oc"},       32'(cur_oc),       32'd0);
  endtask

  task automatic start_layer(input logic [2:0] op, input logic [15:0] ic,
                             input logic [15:0] oc, input logic [7:0] side);
    op_type   = op;
    i_channel = ic;
    o_channel = oc;
    o_side    = side;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called on the first cycle engine_valid is high; group_done is presented
  // during the lat-th high cycle. Returns on the next rise, or after idle.
  task automatic do_group(input int ic, input int row, input int oc,
                          input int lat, input bit last);
    chk("ev_rise", 32'(engine_valid), 32'd1);
    chk("cur_ic",  32'(cur_ic),  32'(ic));
    chk("cur_row", 32'(cur_row), 32'(row));
    chk("cur_oc",  32'(cur_oc),  32'(oc));
    repeat (lat - 1) tick();
    chk("ev_hold", 32'(engine_valid), 32'd1);
    chk("err_run", 32'(err), 32'd0);
    group_done = 1'b1;
    tick();
    group_done = 1'b0;
    chk("ev_fall", 32'(engine_valid), 32'd0);
    chk("done_next", 32'(done), 32'd0);
    tick();
    if (last) begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_done",  32'(busy), 32'd1);
      chk("ev_done",    32'(engine_valid), 32'd0);
      tick();
      chk("done_clear", 32'(done), 32'd0);
      chk("busy_fall",  32'(busy), 32'd0);
    end else begin
      chk("ev_gap",   32'(engine_valid), 32'd0);
      chk("done_gap", 32'(done), 32'd0);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int high_cnt;
    int done_cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; group_done = 1'b0;
    op_type = '0; i_channel = '0; o_channel = '0; o_side = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // CONV 16/2/2: 8 groups; inputs changed after start must not matter.
    start_layer(3'd1, 16'd16, 16'd2, 8'd2);
    chk("conv_busy", 32'(busy), 32'd1);
    op_type = '0; i_channel = '0; o_channel = '0; o_side = '0;
    for (int oc = 0; oc < 2; oc++)
      for (int row = 0; row < 2; row++)
        for (int ic = 0; ic < 16; ic += 8)
          do_group(ic, row, oc, 10, (oc == 1) && (row == 1) && (ic == 8));
    chk("conv_final_oc", 32'(cur_oc), 32'd2);
    chk("conv_final_ic", 32'(cur_ic), 32'd0);
    chk("conv_err", 32'(err), 32'd0);
    tick();

    // MPOOL 8/3/16: 6 groups, oc steps by 8.
    start_layer(3'd2, 16'd8, 16'd16, 8'd3);
    for (int oc = 0; oc < 16; oc += 8)
      for (int row = 0; row < 3; row++)
        do_group(0, row, oc, 4, (oc == 8) && (row == 2));
    chk("mpool_final_oc", 32'(cur_oc), 32'd16);

    // APOOL with i_channel=12: two ic groups for the single row.
    start_layer(3'd3, 16'd12, 16'd8, 8'd1);
    do_group(0, 0, 0, 3, 1'b0);
    do_group(8, 0, 0, 3, 1'b1);

    // Bad config: op_type 0.
    start_layer(3'd0, 16'd8, 16'd8, 8'd1);
    chk("bad_op_err",  32'(err), 32'd1);
    chk("bad_op_code", 32'(err_code), 32'd1);
    chk("bad_op_busy", 32'(busy), 32'd1);
    chk("bad_op_ev",   32'(engine_valid), 32'd0);
    repeat (3) tick();
    chk("bad_op_hold_err", 32'(err), 32'd1);
    chk("bad_op_hold_ev",  32'(engine_valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_err",  32'(err), 32'd0);
    chk("abort_code", 32'(err_code), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // Bad config: o_side 0.
    start_layer(3'd1, 16'd8, 16'd8, 8'd0);
    chk("bad_side_err",  32'(err), 32'd1);
    chk("bad_side_code", 32'(err_code), 32'd1);
    chk("bad_side_ev",   32'(engine_valid), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort2_err", 32'(err), 32'd0);

    // Watchdog: no group_done -> exactly 20 high cycles, then timeout.
    start_layer(3'd1, 16'd8, 16'd1, 8'd1);
    high_cnt = 0;
    for (int i = 0; i < 40 && engine_valid; i++) begin
      high_cnt++;
      tick();
    end
    chk("wd_high_cycles", 32'(high_cnt), 32'd20);
    chk("wd_err",      32'(err), 32'd1);
    chk("wd_err_code", 32'(err_code), 32'd2);
    chk("wd_busy",     32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wd_abort_err", 32'(err), 32'd0);

    // group_done on the 20th high cycle is a success.
    start_layer(3'd1, 16'd8, 16'd1, 8'd1);
    do_group(0, 0, 0, 20, 1'b1);
    chk("wd_edge_err", 32'(err), 32'd0);

    // Abort in the 3rd CONV group.
    start_layer(3'd1, 16'd16, 16'd2, 8'd2);
    do_group(0, 0, 0, 5, 1'b0);
    do_group(8, 0, 0, 5, 1'b0);
    chk("ab_ic",  32'(cur_ic),  32'd0);
    chk("ab_row", 32'(cur_row), 32'd1);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_ev",   32'(engine_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_row_hold", 32'(cur_row), 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) done_cnt++;
      tick();
    end
    chk("ab_no_done", 32'(done_cnt), 32'd0);

    // Fresh start restarts at origin; start while busy is ignored.
    start_layer(3'd1, 16'd16, 16'd2, 8'd2);
    chk("re_ev",  32'(engine_valid), 32'd1);
    chk("re_row", 32'(cur_row), 32'd0);
    start_layer(3'd0, 16'd0, 16'd0, 8'd0);
    chk("busy_start_err", 32'(err), 32'd0);
    chk("busy_start_ev",  32'(engine_valid), 32'd1);

    // Reset in RUN.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_run");

    // Reset in ERR.
    start_layer(3'd5, 16'd8, 16'd8, 8'd1);
    chk("err_pre_rst", 32'(err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_err");

    // Spurious group_done in IDLE.
    group_done = 1'b1;
    tick();
    group_done = 1'b0;
    tick();
    chk("idle_gd_ev",   32'(engine_valid), 32'd0);
    chk("idle_gd_busy", 32'(busy), 32'd0);
    chk("idle_gd_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/layer_sched.md
# layer_sched

Layer scheduler that sequences the convolution/pooling engine through one full layer. On `start` it holds `engine_valid` for each channel group until the engine reports that group complete. It then advances input-channel, output-row and output-channel counters that mirror the engine's own, and pulses `done` after the final group. It sits between the command/status block and the engine, and adds a watchdog and abort path.

## Interface
- `BURST_LEN`, 8: channels processed per group; `i_channel` step.
- `TIMEOUT`, 65535: cycles allowed in RUN without `group_done` before error.
- `clk` input 1: clock.
- `rst` input 1: reset; synchronous, active-high.
- `start` input 1: single-cycle layer start request.
- `abort` input 1: cancel the current layer.
- `op_type` input 3: 1 = CONV, 2 = MPOOL, 3 = APOOL; sampled on accepted `start`.
- `i_channel` input 16: input channel count; sampled on `start`.
- `o_channel` input 16: output channel count; sampled on `start`.
- `o_side` input 8: output rows per channel; sampled on `start`.
- `group_done` input 1: engine pulse, one channel group finished (engine clear state).
- `engine_valid` output 1: run/advance command to the engine.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse at layer completion.
- `err` output 1: sticky error flag.
- `err_code` output 2: 0 = none, 1 = bad config, 2 = timeout.
- `cur_ic` output 16: current input-channel base.
- `cur_row` output 8: current output row.
- `cur_oc` output 16: current output-channel base.

## Operation
- Reset values: all outputs 0; state IDLE; all counters and the watchdog 0.
- States: IDLE, RUN, NEXT, GAP, DONE, ERR.
- IDLE:
  - An accepted `start` latches the configuration and clears the counters.
  - Bad config is `op_type` outside 1..3, or any of `i_channel`, `o_side`, `o_channel` equal to 0. On bad config: go to ERR with `err_code`=1; `engine_valid` never rises.
  - Otherwise go to RUN.
- `start` outside IDLE is ignored.
- RUN:
  - `engine_valid`=1 for every cycle in this state.
  - The watchdog increments each cycle and is cleared on entry to RUN.
  - `group_done` → NEXT.
  - Watchdog reaching `TIMEOUT-1` without `group_done` → ERR, `err_code`=2.
- NEXT: `engine_valid`=0; one counter update, then GAP or DONE:
  - If `cur_ic+BURST_LEN < i_channel`: `cur_ic += BURST_LEN`.
  - Otherwise `cur_ic`=0 and the row advances:
    - If `cur_row+1 < o_side`: `cur_row += 1`.
    - Otherwise `cur_row`=0 and `cur_oc` steps by 1 (CONV) or `BURST_LEN` (pools). If the stepped `cur_oc >= o_channel` → DONE; else → GAP.
- GAP: `engine_valid`=0 for exactly one cycle, so the engine can return from clear to idle, then → RUN.
- DONE: `done`=1 for one cycle, then → IDLE. Counters keep their final values until the next accepted `start`.
- ERR:
  - `engine_valid`=0.
  - `err`, `err_code` and counters hold.
  - Leaves only on `abort` (→ IDLE, `err` and `err_code` cleared) or `rst`.
- `abort` in any non-IDLE state → IDLE next cycle:
  - `engine_valid`=0 that cycle; no `done` pulse.
  - Counters hold; `err` is cleared.
- Precedence on a simultaneous event: `rst` > `abort` > `group_done` > watchdog expiry. A `group_done` on the expiry cycle counts as success.
- `group_done` outside RUN is ignored.
- Arithmetic is unsigned. Compare with 17-bit sums so that `cur_ic+BURST_LEN` and `cur_oc+BURST_LEN` cannot wrap.

## Timing
- All outputs are registered.
- `engine_valid` rises the cycle after the accepted `start`.
- `engine_valid` falls the cycle after `group_done` is sampled.
- Low gap between groups: exactly 2 cycles (NEXT + GAP).
- `done` is asserted 2 cycles after the final `group_done` (NEXT, then DONE); `busy` falls the cycle after `done`.
- Total groups = ceil(`i_channel`/`BURST_LEN`) × `o_side` × ceil(`o_channel`/step).
- `busy` rises the cycle after `start`. For bad config, `err` rises that same cycle.

## Test plan
- CONV run, `BURST_LEN`=8, `i_channel`=16, `o_side`=2, `o_channel`=2; the engine model pulses `group_done` 10 cycles after each `engine_valid` rise → 8 `engine_valid` bursts, every gap exactly 2 cycles. The (ic,row,oc) sequence runs (0,0,0), (8,0,0), (0,1,0), … (8,1,1). Single `done`; `err`=0.
- MPOOL run, `i_channel`=8, `o_side`=3, `o_channel`=16 → 6 groups, `cur_oc` sequence 0,8, `done` after the 6th `group_done`. Non-multiple case `i_channel`=12 → 2 ic groups per row.
- `op_type`=0 or `o_side`=0 with `start` → `err`=1 and `err_code`=1 next cycle, `engine_valid` stays 0. `abort` → IDLE with `err`=0.
- `TIMEOUT`=20, no `group_done` → `engine_valid` high exactly 20 cycles, then ERR with `err_code`=2. A `group_done` on the 20th cycle instead → NEXT, no error.
- `abort` mid-RUN in the 3rd group → `engine_valid` 0 next cycle, `busy` 0, no `done`. A fresh `start` then restarts at (0,0,0). `start` pulses while busy are ignored.
- `rst` asserted in RUN and in ERR → all outputs 0 next cycle; a spurious `group_done` in IDLE produces no activity.
